// File: rtl/hd44780_ctrl.sv
// HD44780 character-LCD controller.
// Owns a ROWS x COLS character buffer. After power-up it runs the
// controller's initialisation sequence. On each refresh request it rewrites
// every row: one DDRAM address command per row, followed by that row's
// characters. BUS_WIDTH selects 4-bit (two nibbles per byte) or 8-bit
// (one word per byte) transfers. Only 4 and 8 are meaningful.
module hd44780_ctrl #(
    parameter int BUS_WIDTH = 4,
    parameter int ROWS      = 4,
    parameter int COLS      = 16,
    parameter int T_PWRUP   = 50000,
    parameter int T_INIT    = 2500,
    parameter int T_EN      = 20,
    parameter int T_CMD     = 20,
    parameter int T_CLR     = 500
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trg,
    input  logic                 wr_en,
    input  logic [1:0]           wr_row,
    input  logic [4:0]           wr_col,
    input  logic [7:0]           wr_data,
    output logic                 ready,
    output logic                 busy,
    output logic                 e,
    output logic                 rs,
    output logic [BUS_WIDTH-1:0] db
);

    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Function set: DL for an 8-bit bus, N for a multi-line display.
    localparam logic [7:0] FS = 8'h20 | ((BUS_WIDTH == 8) ? 8'h10 : 8'h00)
                                      | ((ROWS > 1) ? 8'h08 : 8'h00);
    localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);
    localparam logic [4:0] LAST_COL = 5'(COLS - 1);

    typedef enum logic [2:0] {
        PWR_WAIT, INIT_FS0, INIT_CMDS, IDLE, ROW_ADDR, ROW_DATA, NEXT_ROW
    } state_t;

    // Progress of the transfer in flight. PH_NONE means the bus is quiet.
    typedef enum logic [2:0] {
        PH_NONE, PH_SETUP, PH_HIGH, PH_LOW, PH_WAIT
    } phase_t;

    // Power-on content is blanks. Reset deliberately leaves the text intact.
    logic [7:0] mem [0:(1<<AW)-1] = '{default: 8'h20};

    state_t        state;
    phase_t        phase;
    logic [31:0]   cnt;
    logic [1:0]    row;
    logic [1:0]    idx;
    logic [4:0]    col;
    logic          pending;
    logic          second;
    logic          single;
    logic [7:0]    tx_byte;
    logic          tx_rs;

    logic          wr_ok;
    logic [AW-1:0] wr_idx;
    logic [4:0]    rd_col;
    logic [AW-1:0] rd_idx;
    logic [7:0]    ld_byte;
    logic          ld_rs;
    logic          ld_single;
    logic [31:0]   wait_len;
    logic          wait_done;
    logic          start;

    function automatic logic [7:0] cmd_byte(input logic [1:0] i);
        case (i)
            2'd0:    return FS;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'(COLS);
            default: return 8'(64 + COLS);
        endcase
    endfunction

    assign wr_ok  = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
    assign wr_idx = AW'(int'(wr_row) * COLS + int'(wr_col));

    // Character buffer write port, open on every cycle including refreshes.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Each state has exactly one possible next byte. Decode it here so the
    // FSM can load it on the edge where the previous byte completes.
    always_comb begin
        rd_col    = (state == ROW_DATA) ? col + 5'd1 : 5'd0;
        rd_idx    = AW'(int'(row) * COLS + int'(rd_col));
        ld_rs     = (state == ROW_ADDR) || (state == ROW_DATA);
        ld_single = (state == PWR_WAIT);
        case (state)
            INIT_CMDS:          ld_byte = cmd_byte(idx + 2'd1);
            IDLE:               ld_byte = 8'h80 | row_base(2'd0);
            ROW_ADDR, ROW_DATA: ld_byte = mem[rd_idx];
            NEXT_ROW:           ld_byte = 8'h80 | row_base(row + 2'd1);
            default:            ld_byte = FS;
        endcase

        if (state == INIT_FS0)
            wait_len = 32'(T_INIT);
        else if (tx_byte == 8'h01 && !tx_rs)
            wait_len = 32'(T_CLR);
        else
            wait_len = 32'(T_CMD);
        wait_done = (phase == PH_WAIT) && (cnt == wait_len - 32'd1);

        case (state)
            PWR_WAIT:  start = (cnt == 32'(T_PWRUP - 1));
            INIT_FS0:  start = wait_done;
            INIT_CMDS: start = wait_done && (idx != 2'd3);
            IDLE:      start = trg || pending;
            ROW_ADDR:  start = wait_done;
            ROW_DATA:  start = wait_done && (col != LAST_COL);
            NEXT_ROW:  start = (row != LAST_ROW);
            default:   start = 1'b0;
        endcase
    end

    assign busy = !(state == IDLE && !pending);

    // Sequencer and bus engine: byte loading, E strobing, post-byte waits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= PWR_WAIT;
            phase   <= PH_NONE;
            cnt     <= '0;
            row     <= '0;
            col     <= '0;
            idx     <= '0;
            pending <= 1'b0;
            second  <= 1'b0;
            single  <= 1'b0;
            tx_byte <= '0;
            tx_rs   <= 1'b0;
            ready   <= 1'b0;
            e       <= 1'b0;
            rs      <= 1'b0;
            db      <= '0;
        end else begin
            if (start) begin
                tx_byte <= ld_byte;
                tx_rs   <= ld_rs;
                single  <= ld_single;
                second  <= 1'b0;
                rs      <= ld_rs;
                db      <= ld_byte[7 -: BUS_WIDTH];
                phase   <= PH_SETUP;
                cnt     <= '0;
            end else begin
                case (phase)
                    PH_SETUP: begin
                        e     <= 1'b1;
                        phase <= PH_HIGH;
                        cnt   <= '0;
                    end
                    PH_HIGH: begin
                        if (cnt == 32'(T_EN - 1)) begin
                            e     <= 1'b0;
                            phase <= PH_LOW;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    PH_LOW: begin
                        if (cnt == 32'(T_EN - 1)) begin
                            // The init wake-up is a lone upper nibble.
                            if (BUS_WIDTH == 4 && !single && !second) begin
                                second <= 1'b1;
                                db     <= tx_byte[BUS_WIDTH-1:0];
                                phase  <= PH_SETUP;
                            end else begin
                                phase <= PH_WAIT;
                            end
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    PH_WAIT: begin
                        if (wait_done) begin
                            phase <= PH_NONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    default: cnt <= (state == PWR_WAIT) ? cnt + 32'd1 : '0;
                endcase
            end

            // Requests outside IDLE merge into one pending refresh.
            if (state == IDLE)
                pending <= 1'b0;
            else if (trg)
                pending <= 1'b1;

            case (state)
                PWR_WAIT: begin
                    if (start) state <= INIT_FS0;
                end
                INIT_FS0: begin
                    if (wait_done) begin
                        state <= INIT_CMDS;
                        idx   <= 2'd0;
                    end
                end
                INIT_CMDS: begin
                    if (wait_done) begin
                        if (idx == 2'd3) begin
                            ready <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                IDLE: begin
                    if (trg || pending) begin
                        row   <= 2'd0;
                        state <= ROW_ADDR;
                    end
                end
                ROW_ADDR: begin
                    if (wait_done) begin
                        col   <= 5'd0;
                        state <= ROW_DATA;
                    end
                end
                ROW_DATA: begin
                    if (wait_done) begin
                        if (col == LAST_COL)
                            state <= NEXT_ROW;
                        else
                            col <= col + 5'd1;
                    end
                end
                NEXT_ROW: begin
                    if (row == LAST_ROW) begin
                        state <= IDLE;
                    end else begin
                        row   <= row + 2'd1;
                        state <= ROW_ADDR;
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_hd44780_ctrl.sv
// Scoreboard bench for hd44780_ctrl: a 4-bit 2x4 instance and an 8-bit 1x4 instance.
module tb_hd44780_ctrl;

    typedef struct packed {
        logic       rs;
        logic [7:0] db;
    } xfer_t;

    logic       clk = 1'b0;
    logic       rst4, trg4, wr_en4, ready4, busy4, e4, rs4;
    logic [1:0] wr_row4;
    logic [4:0] wr_col4;
    logic [7:0] wr_data4;
    logic [3:0] db4;
    logic       rst8, trg8, wr_en8, ready8, busy8, e8, rs8;
    logic [1:0] wr_row8;
    logic [4:0] wr_col8;
    logic [7:0] wr_data8;
    logic [7:0] db8;

    xfer_t q4[$];
    xfer_t q8[$];
    logic [7:0] model4 [0:1][0:3];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hd44780_ctrl #(.BUS_WIDTH(4), .ROWS(2), .COLS(4), .T_PWRUP(100), .T_INIT(50),
                   .T_EN(2), .T_CMD(4), .T_CLR(10)) dut4 (
        .clk(clk), .rst(rst4), .trg(trg4), .wr_en(wr_en4), .wr_row(wr_row4),
        .wr_col(wr_col4), .wr_data(wr_data4), .ready(ready4), .busy(busy4),
        .e(e4), .rs(rs4), .db(db4));

    hd44780_ctrl #(.BUS_WIDTH(8), .ROWS(1), .COLS(4), .T_PWRUP(100), .T_INIT(50),
                   .T_EN(2), .T_CMD(4), .T_CLR(10)) dut8 (
        .clk(clk), .rst(rst8), .trg(trg8), .wr_en(wr_en8), .wr_row(wr_row8),
        .wr_col(wr_col8), .wr_data(wr_data8), .ready(ready8), .busy(busy8),
        .e(e8), .rs(rs8), .db(db8));

    // Monitor for the 4-bit instance: every E rise pops one expected word.
    xfer_t      m4_x;
    logic       e4_prev = 1'b0;
    logic       rs4_hold = 1'b0;
    logic [3:0] db4_hold = 4'h0;
    always @(negedge clk) begin
        if (e4 && !e4_prev) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL xfer4: unexpected transfer rs=%0d db=%h", rs4, db4);
            end else begin
                m4_x = q4.pop_front();
                if (rs4 !== m4_x.rs || {4'h0, db4} !== m4_x.db) begin
                    errors++;
                    $display("FAIL xfer4: got rs=%0d db=%h expected rs=%0d db=%h",
                             rs4, db4, m4_x.rs, m4_x.db);
                end
            end
            rs4_hold = rs4;
            db4_hold = db4;
        end else if (!e4 && e4_prev && rst4) begin
            checks++;
            if (rs4 !== rs4_hold || db4 !== db4_hold) begin
                errors++;
                $display("FAIL hold4: at E fall rs=%0d db=%h, at E rise rs=%0d db=%h",
                         rs4, db4, rs4_hold, db4_hold);
            end
        end
        e4_prev = e4;
    end

    // Monitor for the 8-bit instance.
    xfer_t      m8_x;
    logic       e8_prev = 1'b0;
    always @(negedge clk) begin
        if (e8 && !e8_prev) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL xfer8: unexpected transfer rs=%0d db=%h", rs8, db8);
            end else begin
                m8_x = q8.pop_front();
                if (rs8 !== m8_x.rs || db8 !== m8_x.db) begin
                    errors++;
                    $display("FAIL xfer8: got rs=%0d db=%h expected rs=%0d db=%h",
                             rs8, db8, m8_x.rs, m8_x.db);
                end
            end
        end
        e8_prev = e8;
    end

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_word4(input logic rs_v, input logic [3:0] w);
        xfer_t x;
        x.rs = rs_v;
        x.db = {4'h0, w};
        q4.push_back(x);
    endtask

    task automatic push_byte4(input logic rs_v, input logic [7:0] b);
        push_word4(rs_v, b[7:4]);
        push_word4(rs_v, b[3:0]);
    endtask

    task automatic push8(input logic rs_v, input logic [7:0] b);
        xfer_t x;
        x.rs = rs_v;
        x.db = b;
        q8.push_back(x);
    endtask

    task automatic push_init4();
        push_word4(1'b0, 4'h2);
        push_byte4(1'b0, 8'h28);
        push_byte4(1'b0, 8'h0C);
        push_byte4(1'b0, 8'h06);
        push_byte4(1'b0, 8'h01);
    endtask

    task automatic push_init8();
        push8(1'b0, 8'h30);
        push8(1'b0, 8'h30);
        push8(1'b0, 8'h0C);
        push8(1'b0, 8'h06);
        push8(1'b0, 8'h01);
    endtask

    task automatic push_refresh4();
        for (int r = 0; r < 2; r++) begin
            push_byte4(1'b0, (r == 0) ? 8'h80 : 8'hC0);
            for (int c = 0; c < 4; c++) push_byte4(1'b1, model4[r][c]);
        end
    endtask

    task automatic write4(input int r, input int c, input logic [7:0] d);
        @(negedge clk);
        wr_row4  = 2'(r);
        wr_col4  = 5'(c);
        wr_data4 = d;
        wr_en4   = 1'b1;
        if (r < 2 && c < 4) model4[r][c] = d;
        @(negedge clk);
        wr_en4 = 1'b0;
    endtask

    task automatic pulse_trg4();
        @(negedge clk);
        trg4 = 1'b1;
        @(negedge clk);
        trg4 = 1'b0;
    endtask

    task automatic wait_idle4(input string name);
        int n = 0;
        while (busy4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy4) begin
            errors++;
            $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, n);
        end
        check_int({name, "_queue_left"}, q4.size(), 0);
    endtask

    // Caller releases rst4 on a falling edge; the next rising edge is cycle 1.
    task automatic run_init4(input string name);
        int e_cyc = 0;
        int r_cyc = 0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (e4 && e_cyc == 0) e_cyc = k;
            if (ready4) begin
                r_cyc = k;
                break;
            end
        end
        check_int({name, "_first_e_cycle"}, e_cyc, 101);
        check_int({name, "_ready_cycle"}, r_cyc, 217);
        @(negedge clk);
        check_int({name, "_queue_left"}, q4.size(), 0);
        check_int({name, "_busy_idle"}, busy4, 0);
    endtask

    initial begin
        rst4 = 1'b1; trg4 = 1'b0; wr_en4 = 1'b0; wr_row4 = '0; wr_col4 = '0; wr_data4 = '0;
        rst8 = 1'b1; trg8 = 1'b0; wr_en8 = 1'b0; wr_row8 = '0; wr_col8 = '0; wr_data8 = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) model4[r][c] = 8'h20;

        #1 rst4 = 1'b0; rst8 = 1'b0;
        #1;
        check_int("reset_e", e4, 0);
        check_int("reset_rs", rs4, 0);
        check_int("reset_db", db4, 0);
        check_int("reset_ready", ready4, 0);
        check_int("reset_busy", busy4, 1);
        repeat (3) @(negedge clk);

        // Power-up and init on both bus widths.
        push_init4();
        push_init8();
        rst4 = 1'b1;
        rst8 = 1'b1;
        run_init4("init4");
        check_int("ready8", ready8, 1);
        check_int("init8_queue_left", q8.size(), 0);

        // Row 1 = "ABCD", row 0 still blanks.
        write4(1, 0, 8'h41);
        write4(1, 1, 8'h42);
        write4(1, 2, 8'h43);
        write4(1, 3, 8'h44);
        push_refresh4();
        pulse_trg4();
        check_int("busy_after_trg", busy4, 1);
        wait_idle4("refresh_abcd");

        // Three requests during a refresh yield exactly one more refresh.
        push_refresh4();
        push_refresh4();
        pulse_trg4();
        repeat (20) @(negedge clk);
        pulse_trg4();
        repeat (30) @(negedge clk);
        pulse_trg4();
        repeat (5) @(negedge clk);
        pulse_trg4();
        wait_idle4("merged_refresh");
        repeat (200) @(negedge clk);
        check_int("no_third_refresh_busy", busy4, 0);
        check_int("no_third_refresh_queue", q4.size(), 0);

        // Out-of-range writes must not land anywhere.
        for (int c = 0; c < 4; c++) write4(1, c, 8'h20);
        write4(2, 4, 8'h5A);
        write4(2, 0, 8'h5A);
        write4(0, 4, 8'h5A);
        write4(3, 3, 8'h5A);
        push_refresh4();
        pulse_trg4();
        wait_idle4("refresh_blank");

        // Reset while E is high on a character transfer.
        write4(0, 0, 8'h48);
        push_refresh4();
        pulse_trg4();
        begin
            int n = 0;
            while (!(e4 && rs4) && n < 500) begin
                @(negedge clk);
                n++;
            end
            check_int("data_e_seen", e4 && rs4, 1);
        end
        #2 rst4 = 1'b0;
        #1;
        check_int("midreset_e", e4, 0);
        check_int("midreset_db", db4, 0);
        check_int("midreset_rs", rs4, 0);
        check_int("midreset_ready", ready4, 0);
        check_int("midreset_busy", busy4, 1);
        q4.delete();
        @(negedge clk);
        @(negedge clk);
        push_init4();
        rst4 = 1'b1;
        run_init4("reinit4");

        // Buffer contents survive reset.
        push_refresh4();
        pulse_trg4();
        wait_idle4("refresh_after_reset");

        // 8-bit single-row refresh.
        push8(1'b0, 8'h80);
        for (int c = 0; c < 4; c++) push8(1'b1, 8'h20);
        @(negedge clk);
        trg8 = 1'b1;
        @(negedge clk);
        trg8 = 1'b0;
        begin
            int n = 0;
            while (busy8 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check_int("refresh8_busy", busy8, 0);
        end
        check_int("refresh8_queue_left", q8.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
